// File: rtl/ram_ctrl4x4.sv
// Small single-port RAM controller: one command at a time, 1-cycle writes and
// reads with a held response until the consumer acknowledges it.
module ram_ctrl4x4 #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          preset,
  input  logic          req,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          rack,
  output logic          ready,
  output logic          wdone,
  output logic          dvalid,
  output logic [DW-1:0] dout,
  output logic [1:0]    dbg_state_o
);

  localparam int DEPTH = 1 << AW;

  // Handshakes: a command transfers at a rising edge where req=1 and ready=1;
  // a response transfers at a rising edge where dvalid=1 and rack=1, and dout
  // is held unchanged while dvalid=1 and rack=0.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_din_q;
  logic [DW-1:0] dout_q;
  logic [DW-1:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = wr ? WRITE : READ;
      WRITE:   state_d = IDLE;
      READ:    state_d = RESP;
      RESP:    if (rack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      cmd_addr_q <= '0;
      cmd_din_q  <= '0;
      dout_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (preset) begin
      // Aborts any in-flight command; the pending WRITE is never committed.
      state_q    <= IDLE;
      cmd_addr_q <= '0;
      cmd_din_q  <= '0;
      dout_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        cmd_addr_q <= addr;
        cmd_din_q  <= din;
      end
      if (state_q == WRITE) mem_q[cmd_addr_q] <= cmd_din_q;
      if (state_q == READ)  dout_q <= mem_q[cmd_addr_q];
    end
  end

  assign ready       = (state_q == IDLE);
  assign wdone       = (state_q == WRITE);
  assign dvalid      = (state_q == RESP);
  assign dout        = dout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_ctrl4x4.sv
// Bench for ram_ctrl4x4: directed scenarios plus randomized command mix, checked
// against an array model of the storage and a queue of expected read data.
module tb_ram_ctrl4x4;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          clear, preset, req, wr, rack;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          ready, wdone, dvalid;
  logic [DW-1:0] dout;
  logic [1:0]    dbg_state;

  logic [DW-1:0] model_mem [4];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  ram_ctrl4x4 #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .clear(clear), .preset(preset), .req(req), .wr(wr),
    .addr(addr), .din(din), .rack(rack), .ready(ready), .wdone(wdone),
    .dvalid(dvalid), .dout(dout), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_fill(input logic [DW-1:0] v);
    for (int i = 0; i < 4; i++) model_mem[i] = v;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waitc = 0;
    req = 1'b1; wr = w; addr = a; din = d;
    while (!ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!ready) check("accept_timeout", ready, 1);
    @(negedge clk);
    req = 1'b0; wr = 1'($urandom); addr = AW'($urandom); din = DW'($urandom);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_fill('0);
    check("clear_ready", ready, 1);
    check("clear_dvalid", dvalid, 0);
    check("clear_wdone", wdone, 0);
    check("clear_dout", dout, 0);
  endtask

  task automatic pulse_preset();
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;
    model_fill('1);
    check("preset_ready", ready, 1);
    check("preset_dvalid", dvalid, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d);
    check("wr_wdone_hi", wdone, 1);
    check("wr_ready_lo", ready, 0);
    model_mem[a] = d;
    @(negedge clk);
    check("wr_wdone_lo", wdone, 0);
    check("wr_ready_back", ready, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int delay);
    logic [DW-1:0] e;
    issue(1'b0, a, '0);
    exp_q.push_back(model_mem[a]);
    check("rd_dvalid_early", dvalid, 0);
    check("rd_ready_lo", ready, 0);
    rack = 1'($urandom);
    @(negedge clk);
    check("rd_dvalid", dvalid, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check("rd_data", dout, e);
    for (int k = 0; k < delay; k++) begin
      rack = 1'b0;
      @(negedge clk);
      check("rd_hold_dvalid", dvalid, 1);
      check("rd_hold_dout", dout, e);
      check("rd_hold_ready", ready, 0);
    end
    rack = 1'b1;
    @(negedge clk);
    check("rd_done_dvalid", dvalid, 0);
    check("rd_done_ready", ready, 1);
    rack = 1'b0;
  endtask

  initial begin
    clear = 1'b1; preset = 1'b0; req = 1'b0; wr = 1'b0; rack = 1'b0;
    addr = '0; din = '0;
    model_fill('0);
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_dvalid", dvalid, 0);
    check("rst_wdone", wdone, 0);
    check("rst_dout", dout, 0);
    clear = 1'b0;
    @(negedge clk);
    check("rst_release_ready", ready, 1);

    // Clear then read of a cleared word.
    pulse_clear();
    do_read(2, 0);

    // Write then read back, read with a slow consumer.
    do_write(1, 4'b0011);
    do_read(1, 0);
    do_read(1, 3);

    // Preset fill, then a write aborted by clear in its WRITE cycle.
    pulse_preset();
    do_read(3, 0);
    issue(1'b1, 0, 4'b0111);
    check("abort_wdone_cycle", wdone, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_fill('0);
    check("abort_wdone_after", wdone, 0);
    check("abort_ready", ready, 1);
    do_read(0, 0);

    // Read aborted by preset in its READ cycle: no response, dout forced to 0.
    do_write(2, 4'b0101);
    issue(1'b0, 2, '0);
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;
    model_fill('1);
    check("rd_abort_dvalid", dvalid, 0);
    check("rd_abort_ready", ready, 1);
    check("rd_abort_dout", dout, 0);

    // Four writes with req held continuously; new command is presented during WRITE.
    pulse_clear();
    req = 1'b1; wr = 1'b1; addr = 0; din = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      int waitc = 0;
      while (!ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      if (!ready) check("hold_accept_timeout", ready, 1);
      @(negedge clk);
      check("hold_wdone", wdone, 1);
      model_mem[i] = DW'(1 << i);
      if (i < 3) begin
        addr = AW'(i + 1);
        din  = DW'(1 << (i + 1));
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) do_read(AW'(i), 0);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op == 0)      pulse_clear();
      else if (op == 1) pulse_preset();
      else if (op < 10) do_write(AW'($urandom), DW'($urandom));
      else              do_read(AW'($urandom), $urandom_range(0, 2));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
